// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with two write ports (ALU and load
// writeback), two combinational read ports with optional same-cycle bypass,
// and a per-register pending scoreboard used by issue logic to stall on
// registers that are still waiting for an outstanding load.
module reg_file_mp #(
    parameter int DW       = 8,
    parameter int AW       = 4,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          pend_set,
    input  logic [AW-1:0] pend_addr,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [DW-1:0] rd_data_a,
    output logic [DW-1:0] rd_data_b,
    output logic          busy_a,
    output logic          busy_b,
    output logic [AW:0]   pend_cnt
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0] r_pend;
    logic [AW:0]      r_cnt;

    logic [DEPTH-1:0] w_pend_nxt;
    logic [AW:0]      w_cnt_nxt;
    logic             w_wr_ok;
    logic             w_ld_ok;
    logic             w_set_ok;
    logic             w_ld_lost;

    // With a hardwired zero register, any access to address 0 is squashed here
    // so storage, pending bits and bypass never see it.
    assign w_wr_ok   = wr_en    && !((ZERO_REG != 0) && (wr_addr   == '0));
    assign w_ld_ok   = ld_en    && !((ZERO_REG != 0) && (ld_addr   == '0));
    assign w_set_ok  = pend_set && !((ZERO_REG != 0) && (pend_addr == '0));
    // ALU writeback wins a same-address collision; the load data is dropped.
    assign w_ld_lost = w_wr_ok && (wr_addr == ld_addr);

    // Read mux: reset forces zero, then zero register, then bypass, then storage.
    function automatic logic [DW-1:0] read_port(input logic [AW-1:0] addr);
        logic [DW-1:0] v;
        v = r_mem[addr];
        if (!rst_n) begin
            v = '0;
        end else if ((ZERO_REG != 0) && (addr == '0)) begin
            v = '0;
        end else if ((BYPASS != 0) && w_wr_ok && (wr_addr == addr)) begin
            v = wr_data;
        end else if ((BYPASS != 0) && w_ld_ok && (ld_addr == addr)) begin
            v = ld_data;
        end
        return v;
    endfunction

    // Next pending vector: a new load issue beats a retiring load on the same register.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_set_ok && (pend_addr == AW'(i))) begin
                w_pend_nxt[i] = 1'b1;
            end else if (w_ld_ok && (ld_addr == AW'(i))) begin
                w_pend_nxt[i] = 1'b0;
            end
        end
    end

    // Popcount of the next pending vector so the count moves in the same edge as the bits.
    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_nxt = w_cnt_nxt + (AW + 1)'(w_pend_nxt[i]);
        end
    end

    // Register storage: both ports write unless they collide, in which case ALU wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_ld_ok && !w_ld_lost) begin
                r_mem[ld_addr] <= ld_data;
            end
            if (w_wr_ok) begin
                r_mem[wr_addr] <= wr_data;
            end
        end
    end

    // Pending scoreboard bits and their registered count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    // Combinational read ports and busy flags (busy reflects registered state only).
    always_comb begin
        rd_data_a = read_port(rd_addr_a);
        rd_data_b = read_port(rd_addr_b);
        busy_a    = r_pend[rd_addr_a];
        busy_b    = r_pend[rd_addr_b];
        pend_cnt  = r_cnt;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the datapath. Width, depth and read bypass are configurable.
- Two independent write ports: ALU writeback (wr_*) and memory-load writeback (ld_*).
- Per-register pending scoreboard: marks registers waiting on an outstanding load so issue logic can stall on them.
- Two combinational read ports (A, B).

Parameters:
DW, 8, data width in bits
AW, 4, address width; DEPTH = 2**AW registers
BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return the pre-write value
ZERO_REG, 0, 1 = register 0 is hardwired to zero

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  ALU write enable
wr_addr  in  AW  ALU write address
wr_data  in  DW  ALU write data
ld_en  in  1  load writeback enable
ld_addr  in  AW  load writeback address
ld_data  in  DW  load writeback data
pend_set  in  1  load issued: mark pend_addr pending
pend_addr  in  AW  register targeted by the issued load
rd_addr_a  in  AW  read address A
rd_addr_b  in  AW  read address B
rd_data_a  out  DW  read data A
rd_data_b  out  DW  read data B
busy_a  out  1  pending bit of rd_addr_a
busy_b  out  1  pending bit of rd_addr_b
pend_cnt  out  AW+1  number of registers currently pending

Behaviour:
- Reset: rst_n low asynchronously clears all registers to 0, all pending bits to 0 and pend_cnt to 0. While in reset, rd_data_a/b = 0 and busy_a/b = 0. Release is synchronous to the next clk edge.
- Reads are combinational from storage (0 cycles latency).
- busy_x = pend[rd_addr_x], combinational, current registered value. Not bypassed.
- Writes take effect at the rising edge.
- Same-cycle write collision (wr_en & ld_en & wr_addr==ld_addr):
  - ALU write wins; the load data is dropped.
  - The pending bit is still cleared.
- Different-address simultaneous writes: both are performed.
- Bypass (BYPASS=1), per read port:
  - if wr_en & wr_addr==rd_addr → wr_data;
  - else if ld_en & ld_addr==rd_addr → ld_data;
  - else the stored value.
  - BYPASS=0: always the stored value.
- Pending scoreboard, evaluated per edge for each register r:
  - set if pend_set & pend_addr==r;
  - else clear if ld_en & ld_addr==r;
  - else hold.
  - Set wins over clear on the same register: a new load is issued as the old one retires.
  - ALU writes do not affect pending bits.
  - pend_set on an already-pending register leaves it pending; no error, count unchanged.
  - ld_en to a non-pending register writes data and leaves the bit at 0.
- pend_cnt: registered popcount of the pending bits, updated in the same edge as the bits. Range 0..DEPTH; no wrap.
- ZERO_REG=1:
  - writes to address 0 from either port are ignored;
  - reads of address 0 return 0, including with bypass;
  - pend_set to 0 is ignored, so busy is never 1 for register 0.
- Reset asserted mid-operation: immediate clear of all registers, pending bits and count. Any in-flight writes in that cycle are lost.
- No X propagation: every output is defined for all in-range addresses. The address space is fully decoded (DEPTH = 2**AW).

Test Plan:
- Reset/basic (defaults): hold rst_n=0 → all rd_data=0 and pend_cnt=0. Release; wr 0x5A→r3; next cycle rd_addr_a=3 → 0x5A, busy_a=0.
- Bypass: same cycle wr_en, wr_addr=7, wr_data=0xC3, rd_addr_a=7.
  - BYPASS=1: rd_data_a=0xC3 in that cycle.
  - BYPASS=0: rd_data_a = old value, and 0xC3 the next cycle.
- Collision: wr_en (r5, 0x11) and ld_en (r5, 0x22) with r5 pending → r5=0x11, pend[5]=0, pend_cnt decrements by 1.
- Scoreboard: pend_set r2, r9, r2 on three cycles → pend_cnt=2, busy for r2 and r9. ld_en r2 with pend_set r2 in the same cycle → r2 stays pending, data written, pend_cnt=2.
- ZERO_REG=1: wr r0=0xFF, ld r0=0xEE, pend_set r0 → rd r0=0 (including same-cycle bypass), busy=0, pend_cnt=0.
- Async reset mid-operation: 16 pending registers, pend_cnt=16. Drop rst_n between clock edges → all outputs 0 immediately, before the next edge.
